// File: rtl/data_memory_ls.sv
// data_memory_ls: byte-addressable little-endian RV32 data memory.
//   Single outstanding valid/ready request, programmable read latency,
//   one-cycle registered response strobe. Handles LB/LH/LW/LBU/LHU and
//   SB/SH/SW; illegal accesses are rejected and flagged via resp_err.
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W
//   accesses; otherwise unaligned accesses are performed byte-wise.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I access size/extension code
//   Address, Write_data   byte address, store data (low bytes for B/H)
//   resp_valid            one-cycle response strobe
//   Read_data, resp_err   extended load data / error flag, 0 unless resp_valid
module data_memory_ls #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Numbit  = 32,
  parameter int unsigned Depth   = 1024,
  parameter int unsigned Latency = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [Numbit-1:0] Address,
  input  logic [Numbit-1:0] Write_data,
  output logic              resp_valid,
  output logic [Numbit-1:0] Read_data,
  output logic              resp_err
);

  localparam int unsigned AddrW = $clog2(Depth);
  // Counter holds at most Latency-2.
  localparam int unsigned CntW  = (Latency > 2) ? $clog2(Latency - 1) : 1;
  localparam logic [CntW-1:0] CntInit = (Latency > 1) ? CntW'(Latency - 2) : '0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Numbit-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [Width-1:0] mem [Depth];

  logic              accept;
  logic [1:0]        size_m1;
  logic              f3_ok;
  logic [Numbit:0]   last_addr;
  logic              range_err;
  logic              st_unsigned_err;
  logic              mis_err;
  logic              req_err;
  logic [AddrW-1:0]  idx [4];
  logic [Width-1:0]  rbyte [4];
  logic [Numbit-1:0] load_ext;

  assign accept = req_valid && req_ready;

  // Access size decode; unknown codes leave size at one byte and flag f3_ok.
  always_comb begin
    f3_ok   = 1'b1;
    size_m1 = 2'd0;
    case (req_funct3)
      3'b000, 3'b100: size_m1 = 2'd0;
      3'b001, 3'b101: size_m1 = 2'd1;
      3'b010:         size_m1 = 2'd3;
      default:        f3_ok   = 1'b0;
    endcase
  end

  // One extra bit so the last byte address cannot overflow past the check.
  assign last_addr       = {1'b0, Address} + (Numbit+1)'(size_m1);
  assign range_err       = last_addr >= (Numbit+1)'(Depth);
  assign st_unsigned_err = req_write && req_funct3[2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_err = ((size_m1 == 2'd1) && Address[0]) ||
                   ((size_m1 == 2'd3) && (Address[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif

  assign req_err = !f3_ok || range_err || st_unsigned_err || mis_err;

  // Byte lanes at Address..Address+3; lanes past the access size are unused.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i]   = Address[AddrW-1:0] + AddrW'(i);
      rbyte[i] = mem[idx[i]];
    end
  end

  always_comb begin
    load_ext = '0;
    case (req_funct3)
      3'b000:  load_ext = {{(Numbit-Width){rbyte[0][Width-1]}}, rbyte[0]};
      3'b001:  load_ext = {{(Numbit-2*Width){rbyte[1][Width-1]}}, rbyte[1], rbyte[0]};
      3'b010:  load_ext = Numbit'({rbyte[3], rbyte[2], rbyte[1], rbyte[0]});
      3'b100:  load_ext = Numbit'(rbyte[0]);
      3'b101:  load_ext = Numbit'({rbyte[1], rbyte[0]});
      default: load_ext = '0;
    endcase
  end

  // Stores commit at the accept edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) <= size_m1) begin
          mem[idx[i]] <= Write_data[i*Width +: Width];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = (req_err || req_write) ? '0 : load_ext;
          err_d   = req_err;
          if (Latency == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    Read_data  = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid && err_q;
  end

endmodule

// File: tb/tb_data_memory_ls.sv
module tb_data_memory_ls;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;

  logic [2:0]  vld, rdy, rv, er;
  logic [31:0] rd0, rd1, rd2;
  logic        rdy_s, rv_s, err_s;
  logic [31:0] rd_s;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    vld = 3'b000;
    if (sel >= 0 && sel < 3) vld[sel] = req_valid;
  end

  always_comb begin
    case (sel)
      1:       begin rdy_s = rdy[1]; rv_s = rv[1]; err_s = er[1]; rd_s = rd1; end
      2:       begin rdy_s = rdy[2]; rv_s = rv[2]; err_s = er[2]; rd_s = rd2; end
      default: begin rdy_s = rdy[0]; rv_s = rv[0]; err_s = er[0]; rd_s = rd0; end
    endcase
  end

  data_memory_ls #(.Depth(Depth), .Latency(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_funct3(req_funct3), .Address(addr), .Write_data(wdata),
    .resp_valid(rv[0]), .Read_data(rd0), .resp_err(er[0])
  );
  data_memory_ls #(.Depth(Depth), .Latency(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_funct3(req_funct3), .Address(addr), .Write_data(wdata),
    .resp_valid(rv[1]), .Read_data(rd1), .resp_err(er[1])
  );
  data_memory_ls #(.Depth(Depth), .Latency(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_funct3(req_funct3), .Address(addr), .Write_data(wdata),
    .resp_valid(rv[2]), .Read_data(rd2), .resp_err(er[2])
  );

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : (s == 2) ? 4 : 1;
  endfunction

  // One request on the selected DUT; response checked against the scoreboard.
  task automatic txn(input string name, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_data);
    int   lat;
    bit   got;
    exp_t ex;
    lat = lat_of(sel);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy_s) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s: req_ready never high", name);
      return;
    end
    req_write = w; req_funct3 = f3; addr = a; wdata = d; req_valid = 1'b1;
    sb.push_back('{e_err, e_data});
    @(negedge clk);
    // Scramble inputs after accept: captured fields must be used.
    req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b010;
    addr = $urandom; wdata = $urandom;
    got = 1'b0;
    for (int m = 1; m <= lat + 3 && !got; m++) begin
      if (m > 1) @(negedge clk);
      if (rv_s) begin
        got = 1'b1;
        ex = sb.pop_front();
        n_checks++;
        if (m !== lat) $display("FAIL %s latency: got %0d want %0d", name, m, lat);
        else n_pass++;
        n_checks++;
        if (rd_s !== ex.data) $display("FAIL %s data: got %h want %h", name, rd_s, ex.data);
        else n_pass++;
        n_checks++;
        if (err_s !== ex.err) $display("FAIL %s err: got %b want %b", name, err_s, ex.err);
        else n_pass++;
      end else if (rdy_s !== 1'b0 || rd_s !== 32'h0 || err_s !== 1'b0) begin
        n_checks++;
        $display("FAIL %s busy outputs: ready=%b data=%h err=%b want 0/0/0",
                 name, rdy_s, rd_s, err_s);
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s: no resp_valid within bound", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    @(negedge clk);
    n_checks++;
    if (rv_s !== 1'b0 || rdy_s !== 1'b1)
      $display("FAIL %s strobe end: resp_valid=%b ready=%b want 0/1", name, rv_s, rdy_s);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b010;
    addr = '0; wdata = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (rdy_s !== 1'b1) $display("FAIL reset ready[%0d]: got %b want 1", s, rdy_s);
      else n_pass++;
      n_checks++;
      if (rv_s !== 1'b0 || rd_s !== 32'h0 || err_s !== 1'b0)
        $display("FAIL reset outputs[%0d]: valid=%b data=%h err=%b want 0/0/0",
                 s, rv_s, rd_s, err_s);
      else n_pass++;
    end
    rst_n = 1'b1;
    sel = 0;
  endtask

  task automatic test_store_load();
    sel = 0;
    txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_extend();
    sel = 0;
    txn("sw_20", 1'b1, 3'b010, 32'h20, 32'h80F07F81, 1'b0, 32'h0);
    txn("lb_20", 1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 32'hFFFFFF81);
    txn("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0, 1'b0, 32'h00000081);
    txn("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF80F0);
    txn("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h000080F0);
    txn("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 32'h0000007F);
  endtask

  task automatic test_partial_store();
    sel = 0;
    txn("sw_40", 1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0, 32'h0);
    txn("sb_41", 1'b1, 3'b000, 32'h41, 32'hFFFFFFAA, 1'b0, 32'h0);
    txn("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h1122AA44);
    txn("sh_42", 1'b1, 3'b001, 32'h42, 32'h00005566, 1'b0, 32'h0);
    txn("lw_40b", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h5566AA44);
  endtask

  task automatic test_errors();
    sel = 0;
    txn("sw_50", 1'b1, 3'b010, 32'h50, 32'h55667788, 1'b0, 32'h0);
    txn("lw_oor", 1'b0, 3'b010, Depth - 2, 32'h0, 1'b1, 32'h0);
    txn("sw_f3_011", 1'b1, 3'b011, 32'h50, 32'h01010101, 1'b1, 32'h0);
    txn("sb_f3_100", 1'b1, 3'b100, 32'h50, 32'h000000AA, 1'b1, 32'h0);
    txn("sh_oor", 1'b1, 3'b001, Depth - 1, 32'h00001234, 1'b1, 32'h0);
    txn("lw_hi", 1'b0, 3'b010, 32'h8000_0050, 32'h0, 1'b1, 32'h0);
    txn("lw_50", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h55667788);
    txn("sb_last", 1'b1, 3'b000, Depth - 1, 32'h0000007E, 1'b0, 32'h0);
    txn("lbu_last", 1'b0, 3'b100, Depth - 1, 32'h0, 1'b0, 32'h0000007E);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("sh_31_trap", 1'b1, 3'b001, 32'h31, 32'h0000BEEF, 1'b1, 32'h0);
    txn("lw_52_trap", 1'b0, 3'b010, 32'h52, 32'h0, 1'b1, 32'h0);
    txn("lw_50_keep", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h55667788);
`else
    txn("sh_31", 1'b1, 3'b001, 32'h31, 32'h0000BEEF, 1'b0, 32'h0);
    txn("lhu_31", 1'b0, 3'b101, 32'h31, 32'h0, 1'b0, 32'h0000BEEF);
    txn("sw_61", 1'b1, 3'b010, 32'h61, 32'h01020304, 1'b0, 32'h0);
    txn("lw_61", 1'b0, 3'b010, 32'h61, 32'h0, 1'b0, 32'h01020304);
`endif
  endtask

  // Latency 3 with req_valid held high across three loads.
  task automatic test_back_to_back();
    logic [2:0]  f3s [3];
    logic [31:0] as  [3];
    logic [31:0] es  [3];
    int          acc_t [3];
    int          k, done;
    exp_t        ex;
    sel = 1;
    txn("l3_sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("l3_sw_20", 1'b1, 3'b010, 32'h20, 32'h80F07F81, 1'b0, 32'h0);
    f3s[0] = 3'b010; as[0] = 32'h10; es[0] = 32'hDEADBEEF;
    f3s[1] = 3'b000; as[1] = 32'h20; es[1] = 32'hFFFFFF81;
    f3s[2] = 3'b101; as[2] = 32'h22; es[2] = 32'h000080F0;
    k = 0; done = 0;
    req_write = 1'b0;
    for (int t = 0; t < 60 && done < 3; t++) begin
      @(negedge clk);
      if (k == 3) req_valid = 1'b0;
      if (rv_s) begin
        ex = sb.pop_front();
        n_checks++;
        if ((t - acc_t[done]) !== 3)
          $display("FAIL b2b latency %0d: got %0d want 3", done, t - acc_t[done]);
        else n_pass++;
        n_checks++;
        if (rd_s !== ex.data || err_s !== ex.err)
          $display("FAIL b2b data %0d: got %h/%b want %h/%b", done, rd_s, err_s, ex.data, ex.err);
        else n_pass++;
        done++;
      end
      if (rdy_s && k < 3) begin
        acc_t[k] = t;
        if (k > 0) begin
          n_checks++;
          if ((t - acc_t[k-1]) !== 4)
            $display("FAIL b2b spacing %0d: got %0d want 4", k, t - acc_t[k-1]);
          else n_pass++;
        end
        req_funct3 = f3s[k]; addr = as[k]; req_valid = 1'b1;
        sb.push_back('{1'b0, es[k]});
        k++;
      end else if (k < 3) begin
        addr = $urandom;
        req_funct3 = 3'b111;
      end
    end
    req_valid = 1'b0;
    if (done < 3) begin
      n_checks++;
      $display("FAIL b2b: only %0d of 3 responses", done);
      sb.delete();
    end
  endtask

  // Latency 4: reset during WAIT drops the response but keeps the store.
  task automatic test_reset_in_wait();
    bit got;
    bit seen;
    sel = 2;
    txn("l4_sw_80", 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy_s) got = 1'b1;
    end
    req_write = 1'b1; req_funct3 = 3'b010; addr = 32'h84; wdata = 32'h12345678;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (rdy_s !== 1'b1) $display("FAIL rst_wait ready: got %b want 1", rdy_s);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rv_s) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rst_wait resp: got resp_valid=1 want 0");
    else n_pass++;
    txn("l4_lw_80", 1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'hCAFEF00D);
    txn("l4_lw_84", 1'b0, 3'b010, 32'h84, 32'h0, 1'b0, 32'h12345678);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
